// File: rtl/nasti_rd_burst_ctrl.sv
// NASTI read-burst front-end: expands AR bursts into per-beat scheduler requests, returns R beats in order (opt. NASTI_RD_4KB_CHECK_EN).
// Latency: first rq one cycle after AR accept; R path is combinational from the tag head and rs_*.
// Backpressure: ar_ready drops while issuing or with TAG_DEPTH bursts outstanding; rq/rs/r follow valid/ready.
module nasti_rd_burst_ctrl #(
    parameter int ID_WIDTH   = 9,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]            ar_len,
    input  logic [2:0]            ar_size,
    input  logic [1:0]            ar_burst,
    input  logic [USER_WIDTH-1:0] ar_user,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic [USER_WIDTH-1:0] r_user,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [ADDR_WIDTH-1:0] rq_addr,
    output logic                  rq_valid,
    input  logic                  rq_ready,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic                  rs_err,
    input  logic                  rs_valid,
    output logic                  rs_ready
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam int PW       = $clog2(TAG_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [7:0]            len;
        logic [USER_WIDTH-1:0] user;
        logic                  err;
    } tag_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            issue_cnt_q, issue_cnt_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  ar_ready_q, ar_ready_d;
    tag_t                  tag_q [TAG_DEPTH];
    tag_t                  tag_d [TAG_DEPTH];

    logic                  ar_err;
    logic                  ar_hs;
    logic                  pop;
    logic                  fifo_empty;
    tag_t                  head;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign ar_ready   = ar_ready_q;
    assign ar_hs      = ar_valid && ar_ready_q;
    assign fifo_empty = (count_q == '0);
    assign head       = tag_q[rd_ptr_q];
    assign rq_addr    = addr_q;

    // Bursts that cannot be legally issued are still tagged so the R side answers with SLVERR beats.
    always_comb begin
        ar_err = 1'b0;
        if (ar_burst == 2'b11) begin
            ar_err = 1'b1;
        end
        if (ar_size > 3'(MAX_SIZE)) begin
            ar_err = 1'b1;
        end
        if (ar_burst == 2'b10 && !(ar_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            ar_err = 1'b1;
        end
`ifdef NASTI_RD_4KB_CHECK_EN
        if (ar_burst == 2'b01 &&
            ({2'b00, ar_addr[11:0]} + ((14'(ar_len) + 14'd1) << ar_size)) > 14'd4096) begin
            ar_err = 1'b1;
        end
`endif
    end

    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        incr_addr = addr_q + step;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    always_comb begin
        r_valid  = 1'b0;
        r_data   = '0;
        r_resp   = 2'b00;
        r_last   = 1'b0;
        r_id     = '0;
        r_user   = '0;
        rs_ready = 1'b0;
        if (!fifo_empty) begin
            r_id   = head.id;
            r_user = head.user;
            r_last = (beat_cnt_q == head.len);
            if (head.err) begin
                r_valid = 1'b1;
                r_resp  = 2'b10;
            end else begin
                r_valid  = rs_valid;
                r_data   = rs_data;
                r_resp   = rs_err ? 2'b10 : 2'b00;
                rs_ready = r_ready;
            end
        end
        pop        = r_valid && r_ready && r_last;
        beat_cnt_d = beat_cnt_q;
        if (r_valid && r_ready) begin
            beat_cnt_d = r_last ? 8'd0 : beat_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        issue_cnt_d = issue_cnt_q;
        tag_d       = tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rq_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ar_hs && !ar_err) begin
                    addr_d      = ar_addr;
                    len_d       = ar_len;
                    size_d      = ar_size;
                    burst_d     = ar_burst;
                    issue_cnt_d = 8'd0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                rq_valid = 1'b1;
                if (rq_ready) begin
                    addr_d = next_addr;
                    if (issue_cnt_q == len_q) begin
                        issue_cnt_d = 8'd0;
                        state_d     = IDLE;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ar_hs) begin
            tag_d[wr_ptr_q] = '{id: ar_id, len: ar_len, user: ar_user, err: ar_err};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(ar_hs) - (PW+1)'(pop);

        // Registered from next-state values, so a freed slot or a finished issue shows up one cycle later.
        ar_ready_d = (state_d == IDLE) && (count_d != (PW+1)'(TAG_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ar_ready_q  <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ar_ready_q  <= ar_ready_d;
            tag_q       <= tag_d;
        end
    end

endmodule
